// File: rtl/watch_time_counter.sv
// 24-hour BCD watch time counter with a synchronised 1 Hz tick and a three-state
// set/run mode machine. All outputs are registered; MODE exposes the FSM state.
module watch_time_counter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLOCK,
  input  logic       RST_N,
  input  logic       TICK_1HZ,
  input  logic       KEY_MODE,
  input  logic       KEY_INC,
  output logic [7:0] SEC_BCD,
  output logic [7:0] MIN_BCD,
  output logic [7:0] HOUR_BCD,
  output logic [1:0] MODE,
  output logic       DAY_PULSE
);

  localparam logic [1:0] ST_RUN      = 2'b00;
  localparam logic [1:0] ST_SET_HOUR = 2'b01;
  localparam logic [1:0] ST_SET_MIN  = 2'b10;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   tick;
  logic [1:0]             mode_q, mode_d;
  logic [7:0]             sec_q, sec_d;
  logic [7:0]             min_q, min_d;
  logic [7:0]             hour_q, hour_d;
  logic                   day_q, day_d;

  // BCD 00..59 increment with wrap to 00.
  function automatic logic [7:0] bcd_inc60(input logic [7:0] v);
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd5) return 8'h00;
      return {v[7:4] + 4'd1, 4'd0};
    end
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // BCD 00..23 increment with wrap to 00.
  function automatic logic [7:0] bcd_inc24(input logic [7:0] v);
    if (v == 8'h23) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Rising edge of the synchronised tick; the edge flop resets low so a level
  // already high at reset release still yields one event.
  assign tick = sync_q[SYNC_STAGES-1] & ~edge_q;

  // Priority: KEY_MODE, then KEY_INC (only meaningful in the SET states), then tick.
  always_comb begin
    mode_d = mode_q;
    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    day_d  = 1'b0;
    if (KEY_MODE) begin
      case (mode_q)
        ST_RUN: begin
          mode_d = ST_SET_HOUR;
          sec_d  = 8'h00;
        end
        ST_SET_HOUR: mode_d = ST_SET_MIN;
        default:     mode_d = ST_RUN;
      endcase
    end else if (KEY_INC && mode_q == ST_SET_HOUR) begin
      hour_d = bcd_inc24(hour_q);
    end else if (KEY_INC && mode_q == ST_SET_MIN) begin
      min_d = bcd_inc60(min_q);
    end else if (tick && mode_q == ST_RUN) begin
      sec_d = bcd_inc60(sec_q);
      if (sec_q == 8'h59) begin
        min_d = bcd_inc60(min_q);
        if (min_q == 8'h59) begin
          hour_d = bcd_inc24(hour_q);
          day_d  = (hour_q == 8'h23);
        end
      end
    end
  end

  always_ff @(posedge CLOCK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q <= '0;
      edge_q <= 1'b0;
      mode_q <= ST_RUN;
      sec_q  <= 8'h00;
      min_q  <= 8'h00;
      hour_q <= 8'h00;
      day_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], TICK_1HZ};
      edge_q <= sync_q[SYNC_STAGES-1];
      mode_q <= mode_d;
      sec_q  <= sec_d;
      min_q  <= min_d;
      hour_q <= hour_d;
      day_q  <= day_d;
    end
  end

  assign SEC_BCD   = sec_q;
  assign MIN_BCD   = min_q;
  assign HOUR_BCD  = hour_q;
  assign MODE      = mode_q;
  assign DAY_PULSE = day_q;

endmodule
